seg_scan4: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits next to the 32-bit 4:1 word selector in the element library and generates the 2-bit digit select that walks the digits. It also latches a 16-bit hex value, blanking mask and decimal-point mask with a frame-synchronous load handshake, and decodes the selected nibble into registered active-low anode and segment outputs.

---
 rtl/seg_scan4_if.sv | 24 ++
 rtl/seg_scan4.sv | 139 +++++++++++++
 tb/tb_seg_scan4.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan4_if.sv
// Bundle of the display driver's data/handshake signals.
// The master side supplies the hex value, masks and load strobe.
// The slave side returns the scan state and the active-low drive outputs.
interface seg_scan4_if;
   logic [15:0] hex_in;
   logic [3:0]  point_in;
   logic [3:0]  blank_in;
   logic        load;
   logic        pending;
   logic        frame_start;
   logic [1:0]  digit_sel;
   logic [3:0]  an;
   logic [7:0]  seg;

   modport master (
      output hex_in, point_in, blank_in, load,
      input  pending, frame_start, digit_sel, an, seg
   );

   modport slave (
      input  hex_in, point_in, blank_in, load,
      output pending, frame_start, digit_sel, an, seg
   );
endinterface

// File: rtl/seg_scan4.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// A prescaler walks digit_sel through 0..3. New values are staged on load
// and copied to the display registers only at the frame boundary, so a
// frame never mixes old and new digits. The anode and segment outputs are
// registered and lag digit_sel by one cycle.
module seg_scan4 #(
   parameter int DIV_BITS = 17
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan4_if.slave bus
);

   logic [DIV_BITS-1:0] prescaler_q, prescaler_d;
   logic [1:0]          digit_sel_q, digit_sel_d;
   logic [15:0]         stg_hex_q, stg_hex_d;
   logic [3:0]          stg_point_q, stg_point_d;
   logic [3:0]          stg_blank_q, stg_blank_d;
   logic [15:0]         dsp_hex_q, dsp_hex_d;
   logic [3:0]          dsp_point_q, dsp_point_d;
   logic [3:0]          dsp_blank_q, dsp_blank_d;
   logic                pending_q, pending_d;
   logic                frame_start_q, frame_start_d;
   logic [3:0]          an_q, an_d;
   logic [7:0]          seg_q, seg_d;

   logic                tick;
   logic                commit;
   logic [3:0]          nibble;

   // Hex digit to segments g..a, active-low, decimal point excluded.
   function automatic logic [6:0] decode7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick   = &prescaler_q;
   assign commit = tick && (digit_sel_q == 2'd3);
   assign nibble = dsp_hex_q[{digit_sel_q, 2'b00} +: 4];

   // Next-state: scan counters, staging/display handoff and output decode.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      prescaler_d   = prescaler_q + DIV_BITS'(1);
      digit_sel_d   = digit_sel_q;
      stg_hex_d     = stg_hex_q;
      stg_point_d   = stg_point_q;
      stg_blank_d   = stg_blank_q;
      dsp_hex_d     = dsp_hex_q;
      dsp_point_d   = dsp_point_q;
      dsp_blank_d   = dsp_blank_q;
      pending_d     = pending_q;
      frame_start_d = commit;
      an_d          = 4'b1111;
      seg_d         = 8'hFF;

      if (tick) begin
         digit_sel_d = digit_sel_q + 2'd1;
      end

      // Display takes the staging contents held before this edge; a load on
      // the same edge refills staging and keeps pending set for next frame.
      if (commit) begin
         dsp_hex_d   = stg_hex_q;
         dsp_point_d = stg_point_q;
         dsp_blank_d = stg_blank_q;
         pending_d   = 1'b0;
      end

      if (bus.load) begin
         stg_hex_d   = bus.hex_in;
         stg_point_d = bus.point_in;
         stg_blank_d = bus.blank_in;
         pending_d   = 1'b1;
      end

      if (!dsp_blank_q[digit_sel_q]) begin
         an_d  = ~(4'b0001 << digit_sel_q);
         seg_d = {~dsp_point_q[digit_sel_q], decode7(nibble)};
      end
   end

   // State register with synchronous reset; reset also drops any load.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         prescaler_q   <= '0;
         digit_sel_q   <= '0;
         stg_hex_q     <= '0;
         stg_point_q   <= '0;
         stg_blank_q   <= '0;
         dsp_hex_q     <= '0;
         dsp_point_q   <= '0;
         dsp_blank_q   <= '0;
         pending_q     <= 1'b0;
         frame_start_q <= 1'b0;
         an_q          <= 4'b1111;
         seg_q         <= 8'hFF;
      end else begin
         prescaler_q   <= prescaler_d;
         digit_sel_q   <= digit_sel_d;
         stg_hex_q     <= stg_hex_d;
         stg_point_q   <= stg_point_d;
         stg_blank_q   <= stg_blank_d;
         dsp_hex_q     <= dsp_hex_d;
         dsp_point_q   <= dsp_point_d;
         dsp_blank_q   <= dsp_blank_d;
         pending_q     <= pending_d;
         frame_start_q <= frame_start_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
      end
   end

   assign bus.pending     = pending_q;
   assign bus.frame_start = frame_start_q;
   assign bus.digit_sel   = digit_sel_q;
   assign bus.an          = an_q;
   assign bus.seg         = seg_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Self-checking bench for seg_scan4 with DIV_BITS=2 (dwell 4, frame 16).
// Expected per-digit (an, seg) pairs are queued when a load is driven and
// popped as the DUT scans the following frame.
module tb_seg_scan4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seg_scan4_if bus();

   seg_scan4 #(.DIV_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] exp_q[$];
   logic        held;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
      bus.hex_in   = h;
      bus.point_in = p;
      bus.blank_in = b;
      bus.load     = 1'b1;
      step();
      bus.load     = 1'b0;
   endtask

   task automatic push_slot(input logic [3:0] an, input logic [7:0] seg);
      exp_q.push_back({an, seg});
   endtask

   task automatic push_digits(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
      push_slot(4'b1110, s0);
      push_slot(4'b1101, s1);
      push_slot(4'b1011, s2);
      push_slot(4'b0111, s3);
   endtask

   // Steps until frame_start is seen (bounded); reports whether pending
   // stayed high on every cycle before the commit edge.
   task automatic wait_frame(input string tag, output logic pend_held);
      int n = 0;
      pend_held = 1'b1;
      forever begin
         step();
         n++;
         if (bus.frame_start === 1'b1 || n >= 64) break;
         if (bus.pending !== 1'b1) pend_held = 1'b0;
      end
      check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd1);
   endtask

   // Called right after a commit edge: checks each digit slot at its first
   // and last dwell cycle, then that the next commit follows 16 cycles later.
   task automatic verify_frame(input string tag);
      logic [11:0] e;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_queue%0d", tag, k), 32'(exp_q.size()), 32'(4 - k));
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
         step();
         check($sformatf("%s_slot%0d_first", tag, k), 32'({bus.an, bus.seg}), 32'(e));
         steps(3);
         check($sformatf("%s_slot%0d_last", tag, k), 32'({bus.an, bus.seg}), 32'(e));
      end
      check({tag, "_period"}, 32'(bus.frame_start), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.hex_in   = '0;
      bus.point_in = '0;
      bus.blank_in = '0;
      bus.load     = 1'b0;

      // Reset held 3 cycles.
      steps(3);
      check("rst_an",          32'(bus.an),          32'hF);
      check("rst_seg",         32'(bus.seg),         32'hFF);
      check("rst_digit_sel",   32'(bus.digit_sel),   32'd0);
      check("rst_pending",     32'(bus.pending),     32'd0);
      check("rst_frame_start", 32'(bus.frame_start), 32'd0);
      rst = 1'b0;
      step();
      check("release_an",        32'(bus.an),        32'hE);
      check("release_seg",       32'(bus.seg),       32'hC0);
      check("release_digit_sel", 32'(bus.digit_sel), 32'd0);

      // Mid-frame load of 1234.
      steps(4);
      do_load(16'h1234, 4'b0000, 4'b0000);
      check("load_pending", 32'(bus.pending), 32'd1);
      push_digits(8'h99, 8'hB0, 8'hA4, 8'hF9);
      wait_frame("f1234", held);
      check("f1234_pending_held", 32'(held), 32'd1);
      check("f1234_pending_drop", 32'(bus.pending), 32'd0);
      check("f1234_digit_sel",    32'(bus.digit_sel), 32'd0);
      verify_frame("f1234");

      // Decimal point on digit 1.
      steps(3);
      do_load(16'h1234, 4'b0010, 4'b0000);
      push_digits(8'h99, 8'h30, 8'hA4, 8'hF9);
      wait_frame("fdp", held);
      verify_frame("fdp");

      // Blank digit 3 of F0A5.
      steps(3);
      do_load(16'hF0A5, 4'b0000, 4'b1000);
      push_slot(4'b1110, 8'h92);
      push_slot(4'b1101, 8'h88);
      push_slot(4'b1011, 8'hC0);
      push_slot(4'b1111, 8'hFF);
      wait_frame("fblank", held);
      verify_frame("fblank");

      // AAAA staged, then 5555 loaded exactly on the commit edge.
      steps(3);
      do_load(16'hAAAA, 4'b0000, 4'b0000);
      steps(11);
      bus.hex_in = 16'h5555;
      bus.load   = 1'b1;
      step();
      bus.load   = 1'b0;
      check("coinc_frame_start", 32'(bus.frame_start), 32'd1);
      check("coinc_pending",     32'(bus.pending),     32'd1);
      push_digits(8'h88, 8'h88, 8'h88, 8'h88);
      verify_frame("fA");
      check("fA_next_pending", 32'(bus.pending), 32'd0);
      push_digits(8'h92, 8'h92, 8'h92, 8'h92);
      verify_frame("f5");

      // Reset during digit 2 of 1234, with a load that must be ignored.
      steps(3);
      do_load(16'h1234, 4'b0000, 4'b0000);
      wait_frame("fpre", held);
      steps(9);
      check("pre_rst_an",  32'(bus.an),  32'hB);
      check("pre_rst_seg", 32'(bus.seg), 32'hA4);
      rst        = 1'b1;
      bus.hex_in = 16'hFFFF;
      bus.load   = 1'b1;
      step();
      check("mid_rst_an",        32'(bus.an),        32'hF);
      check("mid_rst_seg",       32'(bus.seg),       32'hFF);
      check("mid_rst_pending",   32'(bus.pending),   32'd0);
      check("mid_rst_digit_sel", 32'(bus.digit_sel), 32'd0);
      rst      = 1'b0;
      bus.load = 1'b0;
      step();
      check("post_rst_an",      32'(bus.an),      32'hE);
      check("post_rst_seg",     32'(bus.seg),     32'hC0);
      check("post_rst_pending", 32'(bus.pending), 32'd0);
      push_digits(8'hC0, 8'hC0, 8'hC0, 8'hC0);
      wait_frame("fpost", held);
      verify_frame("fpost");
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
